// File: rtl/pattern_detect_fsm.sv
// Serial pattern detector: flags a programmable PAT_W-bit sequence (MSB first), overlapping or not.
// match is registered one clock after the hit bit; there is no backpressure, x_valid only qualifies data.
module pattern_detect_fsm #(
    parameter int PAT_W = 4,    // legal 2..16
    parameter int CNT_W = 8     // legal 1..32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic             cfg_overlap,
    input  logic             x_valid,
    input  logic             x,
    input  logic             count_clr,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic [1:0]       state_o
);

    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        UNCFG  = 2'b00,
        FILL   = 2'b01,
        ARMED  = 2'b10,
        ST_BAD = 2'b11
    } state_t;

    state_t             state_q;
    logic [PAT_W-1:0]   pat_q;
    logic               ovl_q;
    logic [PAT_W-1:0]   hist_q;
    logic [FILL_W-1:0]  fill_q;
    logic               match_q;
    logic [CNT_W-1:0]   count_q;

    logic               accept;
    logic               hit;
    logic [PAT_W-1:0]   hist_d;
    logic [FILL_W-1:0]  fill_d;

    // A bit presented alongside cfg_load belongs to the old configuration and is dropped.
    always_comb begin
        accept = x_valid && !cfg_load && ((state_q == FILL) || (state_q == ARMED));
        hist_d = {hist_q[PAT_W-2:0], x};
        fill_d = (fill_q == FILL_MAX) ? fill_q : fill_q + FILL_W'(1);
        hit    = accept && (fill_d == FILL_MAX) && (hist_d == pat_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= UNCFG;
            pat_q   <= '0;
            ovl_q   <= 1'b0;
            hist_q  <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
            count_q <= '0;
        end else begin
            match_q <= hit;

            // Clear wins over a same-cycle hit; a saturated counter simply holds.
            if (count_clr) begin
                count_q <= '0;
            end else if (hit && (count_q != CNT_MAX)) begin
                count_q <= count_q + CNT_W'(1);
            end

            if (cfg_load) begin
                pat_q   <= cfg_pattern;
                ovl_q   <= cfg_overlap;
                hist_q  <= '0;
                fill_q  <= '0;
                state_q <= FILL;
            end else begin
                case (state_q)
                    UNCFG: begin
                        state_q <= UNCFG;
                    end
                    FILL, ARMED: begin
                        if (accept) begin
                            if (hit && !ovl_q) begin
                                hist_q  <= '0;
                                fill_q  <= '0;
                                state_q <= FILL;
                            end else begin
                                hist_q  <= hist_d;
                                fill_q  <= fill_d;
                                state_q <= (fill_d == FILL_MAX) ? ARMED : FILL;
                            end
                        end
                    end
                    default: begin
                        state_q <= UNCFG;
                    end
                endcase
            end
        end
    end

    assign match       = match_q;
    assign match_count = count_q;
    assign state_o     = state_q;

endmodule
